// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: phase FSM, ball run/load gating,
// lives counter and saturating 4-digit BCD score.
module breakout_game_ctrl #(
    parameter int LIVES_INIT        = 3,
    parameter int MISS_PAUSE_FRAMES = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frameTick,
    input  logic        launchBtn,
    input  logic        ballMiss,
    input  logic        brickHit,
    input  logic        bricksCleared,
    output logic        ballRun,
    output logic        ballLoad,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [2:0]  gameState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4,
        WON   = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
    localparam logic [7:0] PAUSE_END = 8'(MISS_PAUSE_FRAMES);

    state_t      state, state_n;
    logic [1:0]  lives_n;
    logic [15:0] score_n;
    logic [7:0]  pause_cnt, pause_n;
    logic        launch_prev;
    logic        launch_edge;

    // Ripple-carry BCD increment that sticks at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign launch_edge = launchBtn & ~launch_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lives       <= LIVES_RST;
            score       <= 16'h0000;
            pause_cnt   <= 8'd0;
            launch_prev <= 1'b1;
        end else begin
            state       <= state_n;
            lives       <= lives_n;
            score       <= score_n;
            pause_cnt   <= pause_n;
            launch_prev <= launchBtn;
        end
    end

    always_comb begin
        state_n = state;
        lives_n = lives;
        score_n = score;
        pause_n = pause_cnt;
        unique case (state)
            IDLE, OVER, WON: begin
                if (launch_edge) begin
                    state_n = SERVE;
                    lives_n = LIVES_RST;
                    score_n = 16'h0000;
                end
            end
            SERVE: begin
                if (launch_edge) state_n = PLAY;
            end
            PLAY: begin
                if (brickHit) score_n = bcd_inc(score);
                if (bricksCleared) begin
                    state_n = WON;
                end else if (ballMiss) begin
                    if (lives <= 2'd1) begin
                        lives_n = 2'd0;
                        state_n = OVER;
                    end else begin
                        lives_n = lives - 2'd1;
                        pause_n = 8'd0;
                        state_n = MISS;
                    end
                end
            end
            MISS: begin
                if (frameTick) begin
                    pause_n = pause_cnt + 8'd1;
                    if (pause_n == PAUSE_END) state_n = SERVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ballRun   = (state == PLAY);
    assign ballLoad  = (state == IDLE) || (state == SERVE) ||
                       (state == OVER) || (state == WON);
    assign gameState = state;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl: phases, lives,
// BCD score saturation and reset during the miss pause.
module tb_breakout_game_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        frameTick;
    logic        launchBtn;
    logic        ballMiss;
    logic        brickHit;
    logic        bricksCleared;
    logic        ballRun;
    logic        ballLoad;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [2:0]  gameState;

    int passed = 0;
    int total  = 0;

    breakout_game_ctrl #(
        .LIVES_INIT       (3),
        .MISS_PAUSE_FRAMES(120)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frameTick    (frameTick),
        .launchBtn    (launchBtn),
        .ballMiss     (ballMiss),
        .brickHit     (brickHit),
        .bricksCleared(bricksCleared),
        .ballRun      (ballRun),
        .ballLoad     (ballLoad),
        .lives        (lives),
        .score        (score),
        .gameState    (gameState)
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are read 1 ns after the edge
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press();
        launchBtn = 1'b0;
        step();
        launchBtn = 1'b1;
        step();
        launchBtn = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frameTick = 1'b1;
            step();
            frameTick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; launchBtn = 1'b1; frameTick = 1'b0;
        ballMiss = 1'b0; brickHit = 1'b0; bricksCleared = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        total++;
        if (gameState !== 3'd0) $display("FAIL reset_state got %0d want 0", gameState);
        else passed++;
        total++;
        if (lives !== 2'd3) $display("FAIL reset_lives got %0d want 3", lives);
        else passed++;
        total++;
        if (score !== 16'h0000) $display("FAIL reset_score got %h want 0000", score);
        else passed++;
        total++;
        if (ballLoad !== 1'b1 || ballRun !== 1'b0)
            $display("FAIL reset_ball got load=%b run=%b want 1 0", ballLoad, ballRun);
        else passed++;
        press();
        total++;
        if (gameState !== 3'd1) $display("FAIL idle_to_serve got %0d want 1", gameState);
        else passed++;
    endtask

    task automatic test_play_score();
        step(2);
        total++;
        if (gameState !== 3'd1) $display("FAIL serve_hold got %0d want 1", gameState);
        else passed++;
        press();
        total++;
        if (gameState !== 3'd2 || ballRun !== 1'b1 || ballLoad !== 1'b0)
            $display("FAIL play_entry got st=%0d run=%b load=%b want 2 1 0",
                     gameState, ballRun, ballLoad);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            brickHit = 1'b1;
            step();
            brickHit = 1'b0;
            step();
        end
        total++;
        if (score !== 16'h0012) $display("FAIL score_12 got %h want 0012", score);
        else passed++;
        press();
        total++;
        if (gameState !== 3'd2) $display("FAIL launch_in_play got %0d want 2", gameState);
        else passed++;
    endtask

    task automatic test_miss_pause();
        ballMiss = 1'b1;
        step();
        total++;
        if (gameState !== 3'd3 || lives !== 2'd2)
            $display("FAIL miss_entry got st=%0d lives=%0d want 3 2", gameState, lives);
        else passed++;
        total++;
        if (ballRun !== 1'b0 || ballLoad !== 1'b0)
            $display("FAIL miss_frozen got run=%b load=%b want 0 0", ballRun, ballLoad);
        else passed++;
        step(4);
        ballMiss = 1'b0;
        total++;
        if (lives !== 2'd2) $display("FAIL miss_level_once got %0d want 2", lives);
        else passed++;
        brickHit = 1'b1;
        step();
        brickHit = 1'b0;
        total++;
        if (score !== 16'h0012) $display("FAIL hit_in_miss got %h want 0012", score);
        else passed++;
        ticks(119);
        total++;
        if (gameState !== 3'd3) $display("FAIL tick_119 got %0d want 3", gameState);
        else passed++;
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        total++;
        if (gameState !== 3'd1) $display("FAIL tick_120 got %0d want 1", gameState);
        else passed++;
    endtask

    task automatic test_game_over();
        press();
        ballMiss = 1'b1;
        step();
        ballMiss = 1'b0;
        total++;
        if (gameState !== 3'd3 || lives !== 2'd1)
            $display("FAIL second_miss got st=%0d lives=%0d want 3 1", gameState, lives);
        else passed++;
        ticks(120);
        press();
        ballMiss = 1'b1;
        brickHit = 1'b1;
        step();
        ballMiss = 1'b0;
        brickHit = 1'b0;
        total++;
        if (gameState !== 3'd4 || lives !== 2'd0)
            $display("FAIL third_miss got st=%0d lives=%0d want 4 0", gameState, lives);
        else passed++;
        total++;
        if (score !== 16'h0013) $display("FAIL hit_with_miss got %h want 0013", score);
        else passed++;
        ballMiss = 1'b1;
        step(2);
        ballMiss = 1'b0;
        total++;
        if (lives !== 2'd0 || ballLoad !== 1'b1)
            $display("FAIL over_hold got lives=%0d load=%b want 0 1", lives, ballLoad);
        else passed++;
        press();
        total++;
        if (gameState !== 3'd1 || lives !== 2'd3 || score !== 16'h0000)
            $display("FAIL over_restart got st=%0d lives=%0d score=%h want 1 3 0000",
                     gameState, lives, score);
        else passed++;
    endtask

    task automatic test_saturate_won();
        press();
        brickHit = 1'b1;
        step(109);
        total++;
        if (score !== 16'h0109) $display("FAIL bcd_carry got %h want 0109", score);
        else passed++;
        step(9998 - 109);
        brickHit = 1'b0;
        total++;
        if (score !== 16'h9998) $display("FAIL score_9998 got %h want 9998", score);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            brickHit = 1'b1;
            step();
            brickHit = 1'b0;
            step();
        end
        total++;
        if (score !== 16'h9999) $display("FAIL score_sat got %h want 9999", score);
        else passed++;
        ballMiss = 1'b1;
        bricksCleared = 1'b1;
        step();
        ballMiss = 1'b0;
        bricksCleared = 1'b0;
        total++;
        if (gameState !== 3'd5 || lives !== 2'd3)
            $display("FAIL won_priority got st=%0d lives=%0d want 5 3", gameState, lives);
        else passed++;
        total++;
        if (ballLoad !== 1'b1 || ballRun !== 1'b0)
            $display("FAIL won_ball got load=%b run=%b want 1 0", ballLoad, ballRun);
        else passed++;
    endtask

    task automatic test_reset_in_miss();
        press();
        press();
        brickHit = 1'b1;
        step();
        brickHit = 1'b0;
        ballMiss = 1'b1;
        step();
        ballMiss = 1'b0;
        ticks(50);
        total++;
        if (gameState !== 3'd3 || score !== 16'h0001)
            $display("FAIL pre_reset got st=%0d score=%h want 3 0001", gameState, score);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (gameState !== 3'd0 || lives !== 2'd3 || score !== 16'h0000)
            $display("FAIL mid_reset got st=%0d lives=%0d score=%h want 0 3 0000",
                     gameState, lives, score);
        else passed++;
        total++;
        if (ballRun !== 1'b0 || ballLoad !== 1'b1)
            $display("FAIL mid_reset_ball got run=%b load=%b want 0 1", ballRun, ballLoad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_play_score();
        test_miss_pause();
        test_game_over();
        test_saturate_won();
        test_reset_in_miss();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
